load_store_unit: RTL
====================

# load_store_unit

Multicycle RV32I load/store unit sitting directly downstream of the ALU: it takes the effective address computed by the ALU's ADD operation (rs1 + imm), performs one data-memory transaction over a req/ack handshake, and returns sign- or zero-extended load data to writeback. It handles byte-lane steering, write masks, alignment checks, illegal-width detection and a bounded memory-wait timeout, all under a small FSM.

## Interface
- `TIMEOUT_CYCLES`, default 16: max cycles `mem_req` is held without `mem_ack` before aborting; legal range 2..255.

- `clk`  input  1  system clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `lsu_start`  input  1  request; accepted only when `lsu_busy`=0
- `lsu_is_store`  input  1  1 = store, 0 = load
- `lsu_funct3`  input  3  RV32I width: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- `lsu_addr`  input  32  effective byte address from ALU result
- `lsu_wdata`  input  32  store data (rs2)
- `lsu_busy`  output  1  high in REQ and DONE states
- `lsu_done`  output  1  one-cycle completion pulse
- `lsu_error`  output  2  valid with `lsu_done`: 00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- `lsu_rdata`  output  32  extended load result; held until next successful load
- `mem_req`  output  1  memory request
- `mem_we`  output  1  write enable, valid with `mem_req`
- `mem_addr`  output  32  word address, `{lsu_addr[31:2], 2'b00}`
- `mem_wdata`  output  32  lane-replicated store data
- `mem_wmask`  output  4  byte write mask (0000 for loads)
- `mem_ack`  input  1  memory completes the transaction this cycle
- `mem_rdata`  input  32  read word, valid when `mem_ack`=1 and `mem_we`=0

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on `lsu_start`=1, register all `lsu_*` inputs and check them. Illegal funct3 (load 011/110/111; store ≥011) → DONE with error 10. Misaligned (halfword with addr[0]=1; word with addr[1:0]≠00) → DONE with error 01. Illegal takes priority over misaligned. Otherwise → REQ.
- REQ: `mem_req`=1; memory outputs driven from registers and stable for the whole state. On `mem_ack` → DONE, error 00. Loads capture the extracted data into `lsu_rdata`.
- Timeout counter: cleared on entry to REQ, increments each REQ cycle without ack. On the `TIMEOUT_CYCLES`-th cycle without ack → DONE with error 11. `mem_ack` in that same cycle wins (error 00).
- DONE: `lsu_done`=1 for exactly one cycle, then IDLE. `lsu_start` is ignored in REQ and DONE.
- Load extraction, lane = addr[1:0]:
  - LB/LBU: byte `mem_rdata[8*lane+:8]`.
  - LH/LHU: halfword `mem_rdata[16*addr[1]+:16]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Store steering:
  - SB: wdata `{4{wdata[7:0]}}`, mask `0001<<lane`.
  - SH: wdata `{2{wdata[15:0]}}`, mask `0011<<lane`.
  - SW: wdata, mask 1111.
- Error or store completion leaves `lsu_rdata` unchanged. No memory request is ever issued for error 01/10.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, counter 0, and all outputs 0 (`lsu_busy`, `lsu_done`, `lsu_error`, `lsu_rdata`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`).
- Start sampled at edge E0. `mem_req` is high in cycle 1. With ack in cycle 1, `lsu_done` is high in cycle 2. Minimum latency is 2 cycles start→done.
- Each wait cycle adds 1 cycle of latency. A fault detected in IDLE gives done in cycle 1, with `mem_req` never asserted.
- On a timeout, `mem_req` is high for exactly `TIMEOUT_CYCLES` cycles and done follows in the next cycle.
- Back-to-back: next start is accepted in the cycle after DONE (`lsu_busy`=0). Peak throughput is one op per 3 cycles.
- `rst` in any state: next cycle is IDLE with all outputs at reset values. `mem_req` drops and no `lsu_done` is produced for the aborted op.
- `lsu_done`, `lsu_error` and `lsu_rdata` are registered outputs. `mem_*` outputs are registered and change only on entry to or exit from REQ.

## Test plan
- LW addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF → `mem_addr`=0x100, mask 0000, done in cycle 2, `lsu_rdata`=0xDEADBEEF, error 00.
- LB addr 0x103 with rdata 0x80_00_00_00 → 0xFFFFFF80; LBU at the same address → 0x00000080; LHU addr 0x102 with rdata 0xBEEF0000 → 0x0000BEEF.
- SH addr 0x206, wdata 0x1234ABCD → `mem_addr`=0x204, `mem_wdata`=0xABCDABCD, mask 1100, `mem_we`=1; `lsu_rdata` unchanged.
- LW addr 0x101 → done in cycle 1 with error 01 and no `mem_req`; store funct3 011 → error 10.
- `TIMEOUT_CYCLES`=4 with no ack → `mem_req` high 4 cycles, done with error 11. Repeat with ack in the 4th cycle → error 00.
- `rst` asserted in the 2nd REQ cycle → `mem_req`=0 next cycle and no done. A `lsu_start` pulsed while busy is ignored, and a start in the cycle after DONE is accepted.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I multicycle load/store unit with req/ack memory port and timeout
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_start,
   input  logic        lsu_is_store,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic [1:0]  lsu_error,
   output logic [31:0] lsu_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state;
   logic [7:0]  wait_cnt;
   logic        is_store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic        illegal;
   logic        misaligned;
   logic [31:0] steer_wdata;
   logic [3:0]  steer_mask;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   always_comb begin
      illegal     = lsu_is_store ? (lsu_funct3 >= 3'd3)
                                 : (lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11);
      misaligned  = (lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
                    (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00);
      steer_wdata = lsu_wdata;
      steer_mask  = 4'b1111;
      case (lsu_funct3[1:0])
         2'b00: begin
            steer_wdata = {4{lsu_wdata[7:0]}};
            steer_mask  = 4'b0001 << lsu_addr[1:0];
         end
         2'b01: begin
            steer_wdata = {2{lsu_wdata[15:0]}};
            steer_mask  = 4'b0011 << lsu_addr[1:0];
         end
         default: ;
      endcase
      if (!lsu_is_store) steer_mask = 4'b0000;
   end

   // Extraction uses the request's registered width and lane, not the live inputs.
   always_comb begin
      byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
      half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'd0, byte_sel};
         3'b101:  load_data = {16'd0, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= 8'd0;
         is_store_q <= 1'b0;
         funct3_q   <= 3'd0;
         lane_q     <= 2'd0;
         lsu_busy   <= 1'b0;
         lsu_done   <= 1'b0;
         lsu_error  <= 2'b00;
         lsu_rdata  <= 32'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_wmask  <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (lsu_start) begin
                  is_store_q <= lsu_is_store;
                  funct3_q   <= lsu_funct3;
                  lane_q     <= lsu_addr[1:0];
                  lsu_busy   <= 1'b1;
                  if (illegal || misaligned) begin
                     state     <= S_DONE;
                     lsu_done  <= 1'b1;
                     lsu_error <= illegal ? 2'b10 : 2'b01;
                  end else begin
                     state     <= S_REQ;
                     wait_cnt  <= 8'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= lsu_is_store;
                     mem_addr  <= {lsu_addr[31:2], 2'b00};
                     mem_wdata <= steer_wdata;
                     mem_wmask <= steer_mask;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack || wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  state     <= S_DONE;
                  lsu_done  <= 1'b1;
                  lsu_error <= mem_ack ? 2'b00 : 2'b11;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= 32'd0;
                  mem_wdata <= 32'd0;
                  mem_wmask <= 4'd0;
                  if (mem_ack && !is_store_q) lsu_rdata <= load_data;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               lsu_done <= 1'b0;
               lsu_busy <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
